// File: rtl/memiq_feedback_ctrl.sv
// memiq_feedback_ctrl: turns i1/i2 LSU cancel information into per-entry
// success/replay feedback for the memory issue queue, and throttles a port
// with a short busy window after it replays.
module memiq_feedback_ctrl #(
  parameter int unsigned PORT_NUM = 2,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned BACKOFF  = 3,
  localparam int unsigned IDXW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PORT_NUM-1:0]      i_iss_vld,
  input  logic [PORT_NUM*IDXW-1:0] i_iss_iqIdx,
  input  logic [PORT_NUM-1:0]      i_i1_cancel,
  input  logic [PORT_NUM-1:0]      i_i2_cancel,
  input  logic                     i_flush,
  output logic [PORT_NUM-1:0]      o_fu_busy,
  output logic [PORT_NUM-1:0]      o_issueSuccess,
  output logic [PORT_NUM-1:0]      o_issueReplay,
  output logic [PORT_NUM*IDXW-1:0] o_feedbackIdx,
  output logic [15:0]              o_replay_cnt
);

  localparam int unsigned CNTW = 4;
  localparam int unsigned POPW = $clog2(PORT_NUM + 1);

  logic [PORT_NUM-1:0] i2_vld;
  logic [PORT_NUM-1:0] i2_c1;
  logic [IDXW-1:0]     i2_idx [PORT_NUM];
  logic [PORT_NUM-1:0] rply_c;
  logic [PORT_NUM-1:0] succ_c;
  logic [CNTW-1:0]     bo_cnt [PORT_NUM];
  logic [POPW-1:0]     rply_pop_c;
  logic [16:0]         cnt_sum_c;

  // i2 stage: capture the i1 op and whether it was already cancelled in i1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i2_vld <= '0;
      i2_c1  <= '0;
      for (int unsigned p = 0; p < PORT_NUM; p++) i2_idx[p] <= '0;
    end else begin
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
        i2_vld[p] <= i_iss_vld[p] & ~i_flush;
        i2_c1[p]  <= i_iss_vld[p] & i_i1_cancel[p];
        if (i_iss_vld[p]) i2_idx[p] <= i_iss_iqIdx[p*IDXW +: IDXW];
      end
    end
  end

  // i2 verdict: any cancel seen in i1 or i2 turns the op into a replay
  always_comb begin
    rply_c = '0;
    succ_c = '0;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      rply_c[p] = i2_vld[p] & (i2_c1[p] | i_i2_cancel[p]);
      succ_c[p] = i2_vld[p] & ~(i2_c1[p] | i_i2_cancel[p]);
    end
  end

  // Feedback pulses; the index only moves when a pulse is produced
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_issueSuccess <= '0;
      o_issueReplay  <= '0;
      o_feedbackIdx  <= '0;
    end else begin
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
        o_issueSuccess[p] <= succ_c[p] & ~i_flush;
        o_issueReplay[p]  <= rply_c[p] & ~i_flush;
        if (i2_vld[p] && !i_flush) o_feedbackIdx[p*IDXW +: IDXW] <= i2_idx[p];
      end
    end
  end

  // Backoff counters: reload on every replay pulse, then count down to idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned p = 0; p < PORT_NUM; p++) bo_cnt[p] <= '0;
    end else begin
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
        if (i_flush)                 bo_cnt[p] <= '0;
        else if (o_issueReplay[p])   bo_cnt[p] <= CNTW'(BACKOFF);
        else if (bo_cnt[p] != '0)    bo_cnt[p] <= bo_cnt[p] - CNTW'(1);
      end
    end
  end

  // Busy mask: at most one port is throttled, the one with more backoff left
  always_comb begin
    o_fu_busy = '0;
    if (bo_cnt[1] > bo_cnt[0])  o_fu_busy[1] = 1'b1;
    else if (bo_cnt[0] != '0)   o_fu_busy[0] = 1'b1;
  end

  // Number of replay pulses this cycle and the saturating sum
  always_comb begin
    rply_pop_c = '0;
    for (int unsigned p = 0; p < PORT_NUM; p++)
      rply_pop_c = rply_pop_c + POPW'(o_issueReplay[p]);
    cnt_sum_c = 17'(o_replay_cnt) + 17'(rply_pop_c);
  end

  // Replay statistics counter; survives flush, saturates instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                o_replay_cnt <= '0;
    else if (cnt_sum_c[16]) o_replay_cnt <= 16'hFFFF;
    else                    o_replay_cnt <= cnt_sum_c[15:0];
  end

endmodule

// File: tb/tb_memiq_feedback_ctrl.sv
// Directed bench for memiq_feedback_ctrl (PORT_NUM=2, DEPTH=8, BACKOFF=3).
module tb_memiq_feedback_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  iss_vld;
  logic [5:0]  iss_idx;
  logic [1:0]  i1c;
  logic [1:0]  i2c;
  logic        flush;
  logic [1:0]  busy;
  logic [1:0]  succ;
  logic [1:0]  rply;
  logic [5:0]  fbidx;
  logic [15:0] rcnt;

  int n_tests = 0;
  int n_fail  = 0;

  memiq_feedback_ctrl #(.PORT_NUM(2), .DEPTH(8), .BACKOFF(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_iss_vld      (iss_vld),
    .i_iss_iqIdx    (iss_idx),
    .i_i1_cancel    (i1c),
    .i_i2_cancel    (i2c),
    .i_flush        (flush),
    .o_fu_busy      (busy),
    .o_issueSuccess (succ),
    .o_issueReplay  (rply),
    .o_feedbackIdx  (fbidx),
    .o_replay_cnt   (rcnt)
  );

  always #5 clk = ~clk;

  // Advance to the next cycle; outputs are sampled and inputs driven 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    iss_vld = 2'b11; iss_idx = 6'o77; i1c = 2'b11; i2c = 2'b11; flush = 1'b0;
    repeat (3) tick();
    chk("rst_succ", 32'(succ), 32'h0);
    chk("rst_rply", 32'(rply), 32'h0);
    chk("rst_idx",  32'(fbidx), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cnt",  32'(rcnt), 32'h0);

    // Nominal success, issued in the first cycle after reset release
    rst = 1'b0; iss_vld = 2'b01; iss_idx = 6'o05; i1c = 2'b00; i2c = 2'b00;
    tick();
    iss_vld = 2'b00; iss_idx = 6'o00;
    chk("t1_succ_early", 32'(succ), 32'h0);
    tick();
    chk("t1_succ", 32'(succ), 32'h1);
    chk("t1_rply", 32'(rply), 32'h0);
    chk("t1_idx",  32'(fbidx), 32'(6'o05));
    chk("t1_busy", 32'(busy), 32'h0);
    tick();
    chk("t1_succ_off", 32'(succ), 32'h0);
    chk("t1_idx_hold", 32'(fbidx), 32'(6'o05));

    // i1 cancel on port 1, then three busy cycles
    iss_vld = 2'b10; iss_idx = 6'o30; i1c = 2'b10;
    tick();
    iss_vld = 2'b00; iss_idx = 6'o00; i1c = 2'b00;
    tick();
    chk("t2_rply", 32'(rply), 32'h2);
    chk("t2_succ", 32'(succ), 32'h0);
    chk("t2_idx",  32'(fbidx), 32'(6'o35));
    chk("t2_busy_t2", 32'(busy), 32'h0);
    tick();
    chk("t2_busy_t3", 32'(busy), 32'h2);
    chk("t2_rply_off", 32'(rply), 32'h0);
    chk("t2_cnt", 32'(rcnt), 32'd1);
    tick(); tick();
    chk("t2_busy_t5", 32'(busy), 32'h2);
    tick();
    chk("t2_busy_t6", 32'(busy), 32'h0);

    // i2 cancel with back-to-back issue on port 0
    iss_vld = 2'b01; iss_idx = 6'o01;
    tick();
    iss_idx = 6'o02; i2c = 2'b01;
    tick();
    iss_vld = 2'b00; iss_idx = 6'o00; i2c = 2'b00;
    chk("t3_rply", 32'(rply), 32'h1);
    chk("t3_succ", 32'(succ), 32'h0);
    chk("t3_idx",  32'(fbidx), 32'(6'o31));
    tick();
    chk("t3_succ2", 32'(succ), 32'h1);
    chk("t3_rply2", 32'(rply), 32'h0);
    chk("t3_idx2",  32'(fbidx), 32'(6'o32));
    chk("t3_busy",  32'(busy), 32'h1);
    chk("t3_cnt",   32'(rcnt), 32'd2);
    repeat (3) tick();
    chk("t3_busy_end", 32'(busy), 32'h0);

    // Simultaneous replays, cancels on empty stages, tie and larger-counter busy
    iss_vld = 2'b11; iss_idx = 6'o76; i1c = 2'b01; i2c = 2'b00;
    tick();
    iss_vld = 2'b00; iss_idx = 6'o00; i1c = 2'b11; i2c = 2'b10;
    chk("t4_quiet", 32'({succ, rply}), 32'h0);
    tick();
    iss_vld = 2'b10; iss_idx = 6'o40; i1c = 2'b10; i2c = 2'b11;
    chk("t4_rply", 32'(rply), 32'h3);
    chk("t4_succ", 32'(succ), 32'h0);
    chk("t4_idx",  32'(fbidx), 32'(6'o76));
    tick();
    iss_vld = 2'b00; iss_idx = 6'o00; i1c = 2'b00; i2c = 2'b00;
    chk("t4_empty_ign", 32'({succ, rply}), 32'h0);
    chk("t4_tie_busy",  32'(busy), 32'h1);
    chk("t4_cnt",       32'(rcnt), 32'd4);
    tick();
    chk("t4_rply_p1", 32'(rply), 32'h2);
    chk("t4_idx_p1",  32'(fbidx), 32'(6'o46));
    chk("t4_tie_busy2", 32'(busy), 32'h1);
    tick();
    chk("t4_big_busy", 32'(busy), 32'h2);
    chk("t4_cnt2",     32'(rcnt), 32'd5);
    tick(); tick();
    chk("t4_busy_t7", 32'(busy), 32'h2);
    tick();
    chk("t4_busy_t8", 32'(busy), 32'h0);

    // Flush: pulses already on the outputs stay, everything behind them drops
    iss_vld = 2'b11; iss_idx = 6'o21; i1c = 2'b11;
    tick();
    iss_idx = 6'o43; i1c = 2'b00;
    tick();
    iss_idx = 6'o65;
    chk("t6_rply", 32'(rply), 32'h3);
    chk("t6_idx",  32'(fbidx), 32'(6'o21));
    tick();
    iss_idx = 6'o70; flush = 1'b1;
    chk("t6_succ_in_flush", 32'(succ), 32'h3);
    chk("t6_idx2", 32'(fbidx), 32'(6'o43));
    chk("t6_busy", 32'(busy), 32'h1);
    chk("t6_cnt",  32'(rcnt), 32'd7);
    tick();
    iss_vld = 2'b00; iss_idx = 6'o00; flush = 1'b0;
    chk("t6_no_pulse1", 32'({succ, rply}), 32'h0);
    chk("t6_busy_clr",  32'(busy), 32'h0);
    chk("t6_idx_hold",  32'(fbidx), 32'(6'o43));
    chk("t6_cnt_kept",  32'(rcnt), 32'd7);
    tick();
    chk("t6_no_pulse2", 32'({succ, rply}), 32'h0);

    // Reset mid-operation with a replay in flight and backoff running
    iss_vld = 2'b01; iss_idx = 6'o03; i1c = 2'b01;
    tick();
    iss_vld = 2'b00; iss_idx = 6'o00; i1c = 2'b00;
    tick();
    iss_vld = 2'b10; iss_idx = 6'o50; i1c = 2'b10;
    chk("t7_rply", 32'(rply), 32'h1);
    chk("t7_idx",  32'(fbidx), 32'(6'o43));
    tick();
    iss_vld = 2'b00; iss_idx = 6'o00; i1c = 2'b00;
    chk("t7_busy_pre", 32'(busy), 32'h1);
    chk("t7_cnt_pre",  32'(rcnt), 32'd8);
    rst = 1'b1;
    #1;
    chk("t7_rst_succ", 32'(succ), 32'h0);
    chk("t7_rst_rply", 32'(rply), 32'h0);
    chk("t7_rst_idx",  32'(fbidx), 32'h0);
    chk("t7_rst_busy", 32'(busy), 32'h0);
    chk("t7_rst_cnt",  32'(rcnt), 32'h0);
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t7_post_rel", 32'({busy, succ, rply}), 32'h0);
    end

    // Saturation of the replay counter
    iss_vld = 2'b11; i1c = 2'b11;
    repeat (32766) tick();
    iss_vld = 2'b01; i1c = 2'b01;
    tick();
    iss_vld = 2'b00; i1c = 2'b00;
    repeat (3) tick();
    chk("t8_near", 32'(rcnt), 32'd65533);
    iss_vld = 2'b11; i1c = 2'b11;
    tick();
    iss_vld = 2'b00; i1c = 2'b00;
    repeat (3) tick();
    chk("t8_full", 32'(rcnt), 32'hFFFF);
    iss_vld = 2'b01; i1c = 2'b01;
    tick();
    iss_vld = 2'b00; i1c = 2'b00;
    repeat (3) tick();
    chk("t8_sat", 32'(rcnt), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
